// File: rtl/iomem_word_bridge.sv
// Bridges 128-bit line requests onto a 32-bit req/gnt/rvalid word port, one beat outstanding at a time.
// Optional per-beat watchdog enabled by IOMEM_BRIDGE_TIMEOUT_EN (aborts with err_o and a 0xDEADBEEF line).
module iomem_word_bridge #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [127:0]      req_data_i,
    input  logic [15:0]       req_rw_i,
    output logic              res_ready_o,
    output logic              res_valid_o,
    output logic [127:0]      res_data_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_be_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [1:0]          beat_q, beat_d;
    logic [ADDR_W-1:4]   addr_q;
    logic [127:0]        data_q;
    logic [15:0]         rw_q;
    logic [127:0]        line_q, line_d;
    logic [127:0]        res_data_q;
    logic                blk_q;
    logic                accept;
    logic                is_wr;
    logic                tmo;
    logic [2:0]          nb;

    // First beat >= from that must be issued; 4 means none left. Reads (rw==0) use every beat.
    function automatic logic [2:0] next_beat(input logic [15:0] rw, input logic [2:0] from);
        logic [2:0] r;
        r = 3'd4;
        for (int k = 3; k >= 0; k--) begin
            if (k >= int'(from) && (rw == 16'h0 || rw[4*k +: 4] != 4'h0))
                r = 3'(k);
        end
        return r;
    endfunction

    assign is_wr  = (rw_q != 16'h0);
    assign accept = (state_q == IDLE) && !blk_q && req_valid_i;
    assign nb     = next_beat(rw_q, {1'b0, beat_q} + 3'd1);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    beat_d  = next_beat(req_rw_i, 3'd0) & 3'd3;
                end
            end
            ISSUE: begin
                if (mem_gnt_i)
                    state_d = WAIT;
                else if (tmo)
                    state_d = RESP;
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    if (nb[2]) begin
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                        beat_d  = nb[1:0];
                    end
                end else if (tmo) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        line_d = line_q;
        if (state_q == WAIT && mem_rvalid_i && !is_wr)
            line_d[{beat_q, 5'b0} +: 32] = mem_rdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            beat_q     <= 2'd0;
            addr_q     <= '0;
            data_q     <= '0;
            rw_q       <= '0;
            line_q     <= '0;
            res_data_q <= '0;
            blk_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            // Requester sees res_valid_o one cycle late, so the following IDLE cycle refuses new work.
            blk_q   <= (state_q == RESP);
            if (accept) begin
                addr_q <= req_addr_i[ADDR_W-1:4];
                data_q <= req_data_i;
                rw_q   <= req_rw_i;
                line_q <= '0;
            end else begin
                line_q <= line_d;
            end
            if (state_d == RESP && state_q != RESP)
                res_data_q <= tmo ? {4{32'hDEADBEEF}} : (is_wr ? 128'h0 : line_d);
        end
    end

`ifdef IOMEM_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    assign tmo = ((state_q == ISSUE && !mem_gnt_i) || (state_q == WAIT && !mem_rvalid_i))
                 && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= tmo;
            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q == ISSUE || state_q == WAIT)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign err_o = err_q;

    logic unused_ok;
    assign unused_ok = ^req_addr_i[3:0];
`else
    assign tmo   = 1'b0;
    assign err_o = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{req_addr_i[3:0], 32'(TIMEOUT_CYCLES)};
`endif

    assign res_ready_o = (state_q == IDLE) && !blk_q;
    assign res_valid_o = (state_q == RESP);
    assign res_data_o  = res_data_q;

    assign mem_req_o   = (state_q == ISSUE);
    assign mem_we_o    = (state_q == ISSUE) && is_wr;
    assign mem_addr_o  = (state_q == ISSUE) ? {addr_q, beat_q, 2'b00} : '0;
    assign mem_wdata_o = (state_q == ISSUE) ? data_q[{beat_q, 5'b0} +: 32] : 32'h0;
    assign mem_be_o    = (state_q != ISSUE) ? 4'h0 : (is_wr ? rw_q[{beat_q, 2'b0} +: 4] : 4'hF);

endmodule
